// File: rtl/iaaa_pkg.sv
// Shared constants for the register-write decoder, controller and register bank.
// Bit indices follow the decoder's one-hot write-enable layout.
package iaaa_pkg;
  localparam int DATA_W = 16;
  localparam int NREG   = 19;

  localparam int IDX_R1   = 0;
  localparam int IDX_R2   = 1;
  localparam int IDX_R3   = 2;
  localparam int IDX_R4   = 3;
  localparam int IDX_R5   = 4;
  localparam int IDX_R6   = 5;
  localparam int IDX_R7   = 6;
  localparam int IDX_R8   = 7;
  localparam int IDX_R9   = 8;
  localparam int IDX_R10  = 9;
  localparam int IDX_R11  = 10;
  localparam int IDX_R12  = 11;
  localparam int IDX_R13  = 12;
  localparam int IDX_R14  = 13;
  localparam int IDX_PC   = 14;
  localparam int IDX_TOTR = 15;
  localparam int IDX_MDDR = 16;
  localparam int IDX_TR   = 17;
  localparam int IDX_AR   = 18;

  localparam logic [4:0] SEL_NONE = 5'd0;
  localparam logic [4:0] SEL_ALL  = 5'd31;
endpackage

// File: rtl/bank_reg.sv
// One bank register: load wins over increment; increment logic exists only when INC_EN is set.
module bank_reg #(
  parameter int W      = 16,
  parameter bit INC_EN = 1'b0
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)             q <= '0;
    else if (load)            q <= d;
    else if (INC_EN && inc)   q <= q + W'(1);
  end
endmodule

// File: rtl/reg_bank.sv
// Register bank: R1..R14, PC, TOTR, MDDR, TR, AR written from one-cycle-aligned bus data,
// with a registered read port and direct PC/AR taps for the memory interface.
module reg_bank
  import iaaa_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] Bus_in,
  input  logic [NREG-1:0]   RDec_out,
  input  logic              PC_inc,
  input  logic              AR_inc,
  input  logic [4:0]        Rd_sel,
  output logic [DATA_W-1:0] Bus_out,
  output logic [DATA_W-1:0] PC_out,
  output logic [DATA_W-1:0] AR_out
);
  logic [DATA_W-1:0]            bus_d;
  logic [NREG-1:0][DATA_W-1:0]  regs;
  logic [NREG-1:0]              inc_vec;
  logic [DATA_W-1:0]            rd_data;

  // Decoder enables arrive one cycle after the bus data, so writes use the delayed copy.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) bus_d <= '0;
    else          bus_d <= Bus_in;
  end

  always_comb begin
    inc_vec          = '0;
    inc_vec[IDX_PC]  = PC_inc;
    inc_vec[IDX_AR]  = AR_inc;
  end

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    bank_reg #(
      .W      (DATA_W),
      .INC_EN ((i == IDX_PC) || (i == IDX_AR))
    ) u_reg (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .load    (RDec_out[i]),
      .inc     (inc_vec[i]),
      .d       (bus_d),
      .q       (regs[i])
    );
  end

  // Codes outside 1..NREG read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREG; i++)
      if (Rd_sel == 5'(i + 1)) rd_data = regs[i];
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) Bus_out <= '0;
    else          Bus_out <= rd_data;
  end

  assign PC_out = regs[IDX_PC];
  assign AR_out = regs[IDX_AR];
endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: driver pushes model expectations, negedge monitor pops and compares.
module tb_reg_bank;
  import iaaa_pkg::*;

  logic              Clock = 1'b0;
  logic              Reset_n = 1'b0;
  logic [DATA_W-1:0] Bus_in = '0;
  logic [NREG-1:0]   RDec_out = '0;
  logic              PC_inc = 1'b0;
  logic              AR_inc = 1'b0;
  logic [4:0]        Rd_sel = '0;
  logic [DATA_W-1:0] Bus_out, PC_out, AR_out;

  reg_bank dut (
    .Clock(Clock), .Reset_n(Reset_n), .Bus_in(Bus_in), .RDec_out(RDec_out),
    .PC_inc(PC_inc), .AR_inc(AR_inc), .Rd_sel(Rd_sel),
    .Bus_out(Bus_out), .PC_out(PC_out), .AR_out(AR_out)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] bus;
    logic [15:0] pc;
    logic [15:0] ar;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference state: plain integers, register k (1..19) stored at m_reg[k-1].
  int m_reg[19];
  int m_bus_d;
  int m_out;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 19; k++) m_reg[k] = 0;
    m_bus_d = 0;
    m_out   = 0;
  endfunction

  // One rising edge: read sees pre-edge values, writes take the aligned data, writes beat increments.
  function automatic void model_edge(int bi, logic [18:0] dec, bit pci, bit ari, int rs);
    int nxt[19];
    m_out = (rs >= 1 && rs <= 19) ? m_reg[rs-1] : 0;
    for (int k = 0; k < 19; k++) begin
      nxt[k] = m_reg[k];
      if (dec[k])                 nxt[k] = m_bus_d;
      else if (k == 14 && pci)    nxt[k] = (m_reg[k] + 1) % 65536;
      else if (k == 18 && ari)    nxt[k] = (m_reg[k] + 1) % 65536;
    end
    m_reg   = nxt;
    m_bus_d = bi;
  endfunction

  function automatic exp_t mk(string tag);
    exp_t e;
    e.bus = 16'(m_out);
    e.pc  = 16'(m_reg[14]);
    e.ar  = 16'(m_reg[18]);
    e.tag = tag;
    return e;
  endfunction

  task automatic cyc(input string tag, input logic [15:0] bi, input logic [18:0] dec,
                     input bit pci, input bit ari, input logic [4:0] rs);
    @(negedge Clock); #1;
    Reset_n  = 1'b1;
    Bus_in   = bi;
    RDec_out = dec;
    PC_inc   = pci;
    AR_inc   = ari;
    Rd_sel   = rs;
    model_edge(int'(bi), dec, pci, ari, int'(rs));
    q.push_back(mk(tag));
  endtask

  // Reset mid-cycle: outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    @(negedge Clock); #1;
    Reset_n  = 1'b0;
    RDec_out = '0;
    model_reset();
    #1;
    chk({tag, "_async_bus"}, Bus_out, 16'h0);
    chk({tag, "_async_pc"},  PC_out,  16'h0);
    chk({tag, "_async_ar"},  AR_out,  16'h0);
    q.push_back(mk({tag, "_held"}));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, "_bus_out"}, Bus_out, e.bus);
        chk({e.tag, "_pc_out"},  PC_out,  e.pc);
        chk({e.tag, "_ar_out"},  AR_out,  e.ar);
      end
    end
  end

  initial begin : driver
    logic [18:0] dec;
    logic [18:0] ones;
    logic [15:0] r;
    int          budget;
    ones = '1;
    model_reset();
    #12;
    chk("por_bus_out", Bus_out, 16'h0);
    chk("por_pc_out",  PC_out,  16'h0);

    // Single write to R5
    cyc("w_sample", 16'h1234, '0, 0, 0, 5'd5);
    cyc("w_enable", 16'h0000, 19'(1) << 4, 0, 0, 5'd5);
    cyc("w_read",   16'h0000, '0, 0, 0, 5'd5);
    cyc("w_r4",     16'h0000, '0, 0, 0, 5'd4);
    cyc("w_r6",     16'h0000, '0, 0, 0, 5'd6);

    // Broadcast
    cyc("bc_sample", 16'hA5A5, '0, 0, 0, 5'd0);
    cyc("bc_enable", 16'h0000, ones, 0, 0, 5'd0);
    for (int k = 1; k <= 19; k++) cyc("bc_read", 16'h0000, '0, 0, 0, 5'(k));
    cyc("bc_sel0",  16'h0000, '0, 0, 0, 5'd0);
    cyc("bc_sel25", 16'h0000, '0, 0, 0, 5'd25);
    cyc("bc_sel31", 16'h0000, '0, 0, 0, SEL_ALL);
    cyc("bc_flush", 16'h0000, '0, 0, 0, 5'd0);

    // PC wrap and write-over-increment priority
    cyc("pc_sample", 16'hFFFF, '0, 0, 0, 5'd15);
    cyc("pc_load",   16'h0000, 19'(1) << 14, 0, 0, 5'd15);
    cyc("pc_wrap",   16'h0000, '0, 1, 0, 5'd15);
    cyc("pc_s2",     16'h0100, '0, 1, 0, 5'd15);
    cyc("pc_prio",   16'h0000, 19'(1) << 14, 1, 0, 5'd15);
    cyc("pc_after",  16'h0000, '0, 0, 0, 5'd15);

    // AR stream
    cyc("ar_sample", 16'h0010, '0, 0, 0, 5'd19);
    cyc("ar_load",   16'h0000, 19'(1) << 18, 0, 0, 5'd19);
    for (int k = 0; k < 4; k++) cyc("ar_inc", 16'h0000, '0, 0, 1, 5'd19);
    cyc("ar_trail",  16'h0000, '0, 0, 0, 5'd19);

    // Held MDDR enable tracks Bus_in one cycle late
    for (int k = 0; k < 8; k++) begin
      r = 16'($urandom);
      cyc("held_mddr", r, 19'(1) << 16, 0, 0, 5'd17);
    end
    cyc("held_end", 16'h0000, '0, 0, 0, 5'd17);

    // Reset with loaded registers and pending aligned data
    cyc("pre_rst", 16'hBEEF, '0, 0, 0, 5'd1);
    do_reset("rst_mid");
    cyc("rst_rel", 16'h0000, ones, 0, 0, 5'd17);
    for (int k = 1; k <= 19; k++) cyc("rst_read", 16'h0000, '0, 0, 0, 5'(k));
    cyc("rst_flush", 16'h0000, '0, 0, 0, 5'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       dec = '0;
        1:       dec = ones;
        2, 3:    dec = 19'($urandom);
        default: dec = 19'(1) << $urandom_range(0, 18);
      endcase
      if ($urandom_range(0, 3) != 0 && dec != ones) dec = (dec & 19'($urandom)) | '0;
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rnd_rst");
      end else begin
        cyc("rnd", 16'($urandom), dec, 1'($urandom), 1'($urandom), 5'($urandom_range(0, 31)));
      end
    end
    cyc("drain", 16'h0000, '0, 0, 0, 5'd0);

    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(negedge Clock);
      budget--;
    end
    @(posedge Clock);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_bank.md
# reg_bank

Register bank that consumes the 19-bit one-hot write-enable vector produced by the register-write decoder and stores the processor's architectural and datapath registers: R1–R14, PC, TOTR, MDDR, TR and AR. It holds a one-stage data alignment register so bus data presented alongside the decoder select lands in the register enabled one cycle later. It also provides one registered read port onto the main bus and direct PC/AR outputs to the memory interface.

## Interface
- DATA_W, 16, width of every register and bus
- NREG, 19, number of registers (fixed by the decoder vector width)

- Clock  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Bus_in  in  DATA_W  write data, presented in the same cycle as the decoder's select inputs
- RDec_out  in  19  one-hot write enable from the decoder; all-ones means broadcast write
- PC_inc  in  1  increment PC by 1
- AR_inc  in  1  increment AR by 1
- Rd_sel  in  5  read select, same code space as the decoder (1..19)
- Bus_out  out  DATA_W  registered read data
- PC_out  out  DATA_W  current PC, continuous
- AR_out  out  DATA_W  current AR, continuous

Clock is one domain; reset is asynchronous and active-low.

## Operation
- Bit map, LSB first:
  - bits 0..13 = R1..R14
  - bit 14 = PC
  - bit 15 = TOTR
  - bit 16 = MDDR
  - bit 17 = TR
  - bit 18 = AR
- Read code k (1..19) selects bit k-1.
- Alignment stage:
  - bus_d <= Bus_in every cycle, unconditionally.
  - All register writes use bus_d, never Bus_in.
- Write: on each rising edge, every register whose RDec_out bit is 1 loads bus_d.
  - Multiple set bits write all selected registers.
  - All-ones writes all 19.
  - All-zero writes nothing.
  - A held enable rewrites the register every cycle.
- Increment:
  - If PC_inc=1 and RDec_out[14]=0, PC <= PC+1, modulo 2^DATA_W (0xFFFF wraps to 0x0000).
  - AR is the same, using AR_inc and bit 18.
- Priority: a write to PC/AR beats increment in the same cycle; the increment is dropped, not deferred.
- Read: Bus_out <= pre-edge contents of the register selected by Rd_sel.
  - Rd_sel = 0 or 20..31 gives Bus_out <= 0.
  - No write-through bypass.

## Timing
- Reset (Reset_n low, asynchronous): all 19 registers, bus_d and Bus_out go to 0 immediately and stay 0 until the first rising edge after release.
- Write latency:
  - Bus_in sampled at edge N.
  - The enable vector from the decoder (registered from select at edge N) is valid after edge N.
  - The register updates at edge N+1.
- Read latency: 1 cycle.
  - A register written at edge N+1 appears on Bus_out after edge N+2, if Rd_sel selects it at that edge.
- PC_out and AR_out reflect the new value immediately after the updating edge; there is no extra delay.
- Reset asserted mid-sequence discards any aligned data in bus_d; no write occurs on release.

## Structure
- Shared package `iaaa_pkg`:
  - DATA_W and NREG
  - bit-index constants IDX_R1..IDX_R14, IDX_PC, IDX_TOTR, IDX_MDDR, IDX_TR, IDX_AR
  - read codes SEL_NONE=0, SEL_ALL=31
- These are shared with the decoder and the controller.
- Sub-module `bank_reg`:
  - one DATA_W register with load, optional increment, and asynchronous active-low reset
  - INC_EN parameter: 1 for PC/AR, 0 elsewhere
  - instantiated 19 times
- The read mux and the alignment register live in the top.

## Test plan
- Reset: assert Reset_n low mid-run with registers loaded. Required: Bus_out, PC_out and AR_out read 0 immediately; all Rd_sel 1..19 read 0 after release.
- Single write: Bus_in=0x1234 at edge N, RDec_out=bit 4 (R5) after N, Rd_sel=5. Required: R5=0x1234 after N+1, Bus_out=0x1234 after N+2, other registers unchanged.
- Broadcast: Bus_in=0xA5A5, RDec_out=all-ones. Required: every code 1..19 reads 0xA5A5; Rd_sel=0 and 25 read 0.
- PC wrap and priority:
  - PC=0xFFFF with PC_inc=1 gives PC_out=0x0000.
  - PC_inc=1 together with a PC write of 0x0100 gives 0x0100, not 0x0101.
- AR stream: write AR=0x0010, then hold AR_inc=1 for 4 cycles. Required: AR_out steps through 0x0011..0x0014, and Bus_out with Rd_sel=19 trails AR_out by 1 cycle.
- Held enable: RDec_out held at bit 16 (MDDR) while Bus_in changes each cycle. Required: MDDR tracks Bus_in delayed by exactly 1 cycle.
